// File: rtl/registro_solicitudes.sv
// Call-button request register: debounces cabin/hall buttons per floor, latches accepted
// presses until cleared, and summarises pending requests against the current floor.
module registro_solicitudes #(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] btn_cab,
  input  logic [N_FLOORS-1:0] btn_up,
  input  logic [N_FLOORS-1:0] btn_dn,
  input  logic [FLOOR_W-1:0]  floor,
  input  logic [N_FLOORS-1:0] clr_cab,
  input  logic [N_FLOORS-1:0] clr_up,
  input  logic [N_FLOORS-1:0] clr_dn,
  output logic [N_FLOORS-1:0] req_cab,
  output logic [N_FLOORS-1:0] req_up,
  output logic [N_FLOORS-1:0] req_dn,
  output logic                any_above,
  output logic                any_below,
  output logic                any_here,
  output logic                any_req
);

  localparam int NB    = 3 * N_FLOORS;
  localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE - 1);

  logic [NB-1:0]    btn_all, clr_all, valid_mask, acc;
  logic [NB-1:0]    req_q, req_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [N_FLOORS-1:0] pend;

  // Bit layout: [N-1:0] cabin, [2N-1:N] hall-up, [3N-1:2N] hall-down.
  assign btn_all = {btn_dn, btn_up, btn_cab};
  assign clr_all = {clr_dn, clr_up, clr_cab};

  // Top-floor hall-up and ground-floor hall-down do not exist.
  always_comb begin
    valid_mask                 = '1;
    valid_mask[2*N_FLOORS-1]   = 1'b0;
    valid_mask[2*N_FLOORS]     = 1'b0;
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (btn_all[i]) begin
        acc[i]   = (cnt_q[i] == CNT_ARM);
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A clear on the same edge as an accept wins: the press is absorbed by the stop.
  assign req_d = (req_q | acc) & ~clr_all & valid_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      req_q <= '0;
    end else begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      req_q <= req_d;
    end
  end

  assign req_cab = req_q[N_FLOORS-1:0];
  assign req_up  = req_q[2*N_FLOORS-1:N_FLOORS];
  assign req_dn  = req_q[3*N_FLOORS-1:2*N_FLOORS];
  assign pend    = req_cab | req_up | req_dn;
  assign any_req = |pend;

  // An out-of-range floor naturally yields here=0, above=0, below=any_req.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    any_here  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pend[i]) begin
        if (i > int'(floor))  any_above = 1'b1;
        if (i < int'(floor))  any_below = 1'b1;
        if (i == int'(floor)) any_here  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_registro_solicitudes.sv
// Scoreboarded bench for registro_solicitudes: directed scenarios followed by random
// button/clear traffic, compared against a run-length reference model.
module tb_registro_solicitudes;
  localparam int N   = 4;
  localparam int FW  = 2;
  localparam int DEB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  btn_cab, btn_up, btn_dn, clr_cab, clr_up, clr_dn;
  logic [FW-1:0] floor;
  logic [N-1:0]  req_cab, req_up, req_dn;
  logic          any_above, any_below, any_here, any_req;

  int n_checks = 0;
  int n_errors = 0;

  logic [3*N+3:0] sb_q [$];
  int             run_len [3][N];
  logic [N-1:0]   m_req [3];

  always #5 clk = ~clk;

  registro_solicitudes #(.N_FLOORS(N), .FLOOR_W(FW), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_cab(btn_cab), .btn_up(btn_up), .btn_dn(btn_dn), .floor(floor),
    .clr_cab(clr_cab), .clr_up(clr_up), .clr_dn(clr_dn),
    .req_cab(req_cab), .req_up(req_up), .req_dn(req_dn),
    .any_above(any_above), .any_below(any_below), .any_here(any_here), .any_req(any_req)
  );

  // Reference: a press is accepted when its run of consecutive high samples reaches DEB.
  task automatic model_update();
    logic [N-1:0] b [3];
    logic [N-1:0] c [3];
    logic acc;
    b[0] = btn_cab; b[1] = btn_up; b[2] = btn_dn;
    c[0] = clr_cab; c[1] = clr_up; c[2] = clr_dn;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          run_len[t][i] = 0;
          m_req[t][i]   = 1'b0;
        end else begin
          acc = 1'b0;
          if (b[t][i]) begin
            run_len[t][i]++;
            acc = (run_len[t][i] == DEB);
          end else begin
            run_len[t][i] = 0;
          end
          if (c[t][i])  m_req[t][i] = 1'b0;
          else if (acc) m_req[t][i] = 1'b1;
        end
      end
    end
    m_req[1][N-1] = 1'b0;
    m_req[2][0]   = 1'b0;
  endtask

  function automatic logic [3*N+3:0] model_expect();
    logic [N-1:0] pend;
    logic above, below, here;
    int f;
    pend  = m_req[0] | m_req[1] | m_req[2];
    f     = int'(floor);
    above = 1'b0; below = 1'b0; here = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && i > f)  above = 1'b1;
      if (pend[i] && i < f)  below = 1'b1;
      if (pend[i] && i == f) here  = 1'b1;
    end
    return {m_req[0], m_req[1], m_req[2], above, below, here, |pend};
  endfunction

  task automatic step(input logic r, input logic [N-1:0] bc, input logic [N-1:0] bu,
                      input logic [N-1:0] bd, input logic [FW-1:0] f,
                      input logic [N-1:0] cc, input logic [N-1:0] cu, input logic [N-1:0] cd);
    rst_n = r; btn_cab = bc; btn_up = bu; btn_dn = bd; floor = f;
    clr_cab = cc; clr_up = cu; clr_dn = cd;
    @(posedge clk);
    model_update();
    sb_q.push_back(model_expect());
    #3;
  endtask

  task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle's registered outputs are compared against the queued expectation.
  always @(posedge clk) begin
    logic [3*N+3:0] exp_v, act_v;
    #2;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      act_v = {req_cab, req_up, req_dn, any_above, any_below, any_here, any_req};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL scoreboard @%0t: got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  initial begin
    logic [N-1:0]  rb_c, rb_u, rb_d;
    logic [FW-1:0] rf;
    rst_n = 1'b0; btn_cab = '0; btn_up = '0; btn_dn = '0; floor = '0;
    clr_cab = '0; clr_up = '0; clr_dn = '0;
    for (int t = 0; t < 3; t++) begin
      m_req[t] = '0;
      for (int i = 0; i < N; i++) run_len[t][i] = 0;
    end

    for (int k = 0; k < 4; k++)
      step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), '0, '0, '0);
    dchk("reset_req", {req_cab, req_up, req_dn}, 0);
    dchk("reset_sum", {any_above, any_below, any_here, any_req}, 0);
    repeat (2) step(1'b1, '0, '0, '0, 2'd0, '0, '0, '0);
    dchk("release_req", {req_cab, req_up, req_dn}, 0);

    repeat (2) step(1'b1, 4'b0100, '0, '0, 2'd0, '0, '0, '0);
    dchk("deb_2_edges", req_cab, 0);
    step(1'b1, 4'b0100, '0, '0, 2'd0, '0, '0, '0);
    dchk("deb_3_edges", req_cab, 4'b0100);
    step(1'b1, '0, '0, '0, 2'd0, 4'b0100, '0, '0);
    dchk("clear_cab", req_cab, 0);
    repeat (2) step(1'b1, 4'b0100, '0, '0, 2'd0, '0, '0, '0);
    repeat (2) step(1'b1, '0, '0, '0, 2'd0, '0, '0, '0);
    dchk("glitch_2", req_cab, 0);

    repeat (3) step(1'b1, 4'b0100, '0, '0, 2'd0, '0, '0, '0);
    step(1'b1, 4'b0100, '0, '0, 2'd0, 4'b0100, '0, '0);
    dchk("clr_while_held", req_cab, 0);
    repeat (3) step(1'b1, 4'b0100, '0, '0, 2'd0, '0, '0, '0);
    dchk("held_no_reaccept", req_cab, 0);
    step(1'b1, '0, '0, '0, 2'd0, '0, '0, '0);
    repeat (3) step(1'b1, 4'b0100, '0, '0, 2'd0, '0, '0, '0);
    dchk("rearm_accept", req_cab, 4'b0100);
    step(1'b1, '0, '0, '0, 2'd0, 4'b1111, '0, '0);

    repeat (2) step(1'b1, '0, 4'b0010, '0, 2'd0, '0, '0, '0);
    step(1'b1, '0, 4'b0010, '0, 2'd0, '0, 4'b0010, '0);
    dchk("clr_wins_accept", req_up, 0);
    repeat (10) step(1'b1, '0, 4'b1000, 4'b0001, 2'd0, '0, '0, '0);
    dchk("ignored_bits", {req_up, req_dn}, 0);

    repeat (3) step(1'b1, 4'b1001, '0, '0, 2'd0, '0, '0, '0);
    dchk("sum_req", req_cab, 4'b1001);
    dchk("sum_floor0", {any_above, any_below, any_here}, 3'b101);
    step(1'b1, 4'b1001, '0, '0, 2'd2, '0, '0, '0);
    dchk("sum_floor2", {any_above, any_below, any_here}, 3'b110);
    step(1'b1, 4'b1001, '0, '0, 2'd3, '0, '0, '0);
    dchk("sum_floor3", {any_above, any_below, any_here}, 3'b011);
    step(1'b1, '0, '0, '0, 2'd0, 4'b1111, '0, '0);

    repeat (2) step(1'b1, 4'b0010, '0, '0, 2'd0, '0, '0, '0);
    step(1'b0, 4'b0010, '0, '0, 2'd0, '0, '0, '0);
    dchk("mid_reset", req_cab, 0);
    repeat (2) step(1'b1, 4'b0010, '0, '0, 2'd0, '0, '0, '0);
    dchk("post_reset_2", req_cab, 0);
    step(1'b1, 4'b0010, '0, '0, 2'd0, '0, '0, '0);
    dchk("post_reset_3", req_cab, 4'b0010);

    rb_c = '0; rb_u = '0; rb_d = '0; rf = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) rb_c[i] = ~rb_c[i];
        if ($urandom_range(5) == 0) rb_u[i] = ~rb_u[i];
        if ($urandom_range(5) == 0) rb_d[i] = ~rb_d[i];
      end
      if ($urandom_range(7) == 0) rf = 2'($urandom);
      step(($urandom_range(99) != 0), rb_c, rb_u, rb_d, rf,
           ($urandom_range(9) == 0) ? 4'($urandom) : 4'b0,
           ($urandom_range(9) == 0) ? 4'($urandom) : 4'b0,
           ($urandom_range(9) == 0) ? 4'($urandom) : 4'b0);
    end

    step(1'b1, '0, '0, '0, 2'd0, '0, '0, '0);
    @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
